// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Fetch initiator for a synchronous instruction ROM (1-cycle read latency).
// Owns the PC, drives the ROM address and presents {pc, instr} to decode.
//
// Because the ROM registers its address on the clock edge, the address
// driven this cycle must already be the PC of the *next* instruction. So
// irom_a is the combinational pc_next, and pc and the ROM output update on
// the same edge. This makes if_instr always line up with if_pc and gives one
// instruction per cycle, including across taken redirects.
//
// Handshake (valid/ready): an instruction transfers ("fires") on a cycle
// where if_valid & if_ready are both 1. While if_valid=1 and if_ready=0,
// if_pc/if_instr/if_pc_plus1 hold steady. if_valid never depends on if_ready.
// redir/redir_pc belong to the instruction being fired and are looked at
// only on a fire cycle.
//
// Parameters:
//   ADDR_W    word-address width (ROM depth = 2**ADDR_W)
//   DATA_W    instruction width
//   RESET_PC  word address fetched first after reset
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   irom_a        ROM word address (= pc_next)
//   irom_spo      ROM registered read data
//   if_instr      instruction at if_pc
//   if_pc         word address of if_instr
//   if_pc_plus1   if_pc + 1, wrapping (jal link value)
//   if_valid      if_instr/if_pc valid
//   if_ready      decode accepts the instruction
//   redir         taken branch/jump for the fired instruction
//   redir_pc      redirect target
//   halt_req      stop fetching after this cycle
//   resume        leave HALT
//   halted        FSM state observation (1 = HALT)
//
// Optional build macro IFETCH_PERF_EN adds:
//   fetch_cnt     number of fires (saturating)
//   redir_cnt     number of fires with redir=1 (saturating)
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] irom_a,
  input  logic [DATA_W-1:0] irom_spo,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid,
  input  logic              if_ready,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       redir_cnt
`endif
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic              fire;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  // Reset is folded into if_valid so that nothing fires while rst is high.
  assign if_valid    = (state_q == RUN) && !rst;
  assign fire        = if_valid && if_ready;
  assign if_instr    = irom_spo;
  assign if_pc       = pc_q;
  assign if_pc_plus1 = pc_plus1;
  assign halted      = (state_q == HALT);
  assign irom_a      = pc_next;

  // Holding pc when not firing covers both a decode stall and HALT; in HALT
  // the ROM keeps being addressed with pc so its output stays valid for the
  // cycle after resume.
  always_comb begin
    pc_next = pc_q;
    if (rst) begin
      pc_next = RESET_PC_A;
    end else if (fire) begin
      pc_next = redir ? redir_pc : pc_plus1;
    end
  end

  // Next-state logic. halt_req has priority over resume in RUN; a fire in
  // the same cycle still completes because pc_next is independent of state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (resume)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_A;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
    end
  end

`ifdef IFETCH_PERF_EN
  // Counters advance only on fires, so they hold automatically in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (fire && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (fire && redir && (redir_cnt != '1)) redir_cnt <= redir_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch (ADDR_W=5, DATA_W=32, RESET_PC=0).
// A small synchronous ROM model feeds irom_spo. Inputs are driven 1 ns after
// the rising edge, outputs are checked at the same point (away from the edge).
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] irom_a;
  logic [DW-1:0] irom_spo;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus1;
  logic          if_valid;
  logic          if_ready;
  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          halt_req;
  logic          resume;
  logic          halted;
`ifdef IFETCH_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   redir_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  // ROM model: registered read, one-cycle latency.
  always @(posedge clk) irom_spo <= rom[irom_a];

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .irom_a      (irom_a),
    .irom_spo    (irom_spo),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus1 (if_pc_plus1),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .redir       (redir),
    .redir_pc    (redir_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .halted      (halted)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .redir_cnt   (redir_cnt)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Jump from the current (fired) instruction to target in one cycle.
  task automatic jump_to(input logic [AW-1:0] target);
    if_ready = 1'b1;
    redir    = 1'b1;
    redir_pc = target;
    tick();
    redir    = 1'b0;
    redir_pc = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1; redir = 1'b0; redir_pc = '0;
    halt_req = 1'b0; resume = 1'b0;
    tick(); tick();
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got %b exp 0", halted); end
    tests++; if (irom_a !== 5'd0) begin fails++; $display("FAIL rst_irom_a got %0d exp 0", irom_a); end
    tests++; if (if_pc !== 5'd0) begin fails++; $display("FAIL rst_pc got %0d exp 0", if_pc); end
    tests++; if (if_pc_plus1 !== 5'd1) begin fails++; $display("FAIL rst_pc_plus1 got %0d exp 1", if_pc_plus1); end
    rst = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL rel_valid got %b exp 1", if_valid); end
    tests++; if (if_instr !== 32'h00432020) begin fails++; $display("FAIL rel_instr0 got %h exp 00432020", if_instr); end
  endtask

  // pc 0..7 back to back, 3-cycle stall at pc=3, jal at pc=7 to 13.
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      tests++; if (if_pc !== AW'(i)) begin fails++; $display("FAIL seq_pc got %0d exp %0d", if_pc, i); end
      tests++; if (if_instr !== rom[i]) begin fails++; $display("FAIL seq_instr@%0d got %h exp %h", i, if_instr, rom[i]); end
      tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL seq_valid@%0d got %b exp 1", i, if_valid); end
      if (i == 3) begin
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          tests++; if (if_pc !== 5'd3) begin fails++; $display("FAIL stall_pc got %0d exp 3", if_pc); end
          tests++; if (if_instr !== 32'h00831022) begin fails++; $display("FAIL stall_instr got %h exp 00831022", if_instr); end
          tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got %b exp 1", if_valid); end
        end
        if_ready = 1'b1;
      end
      if (i == 7) begin
        tests++; if (if_pc_plus1 !== 5'd8) begin fails++; $display("FAIL jal_link got %0d exp 8", if_pc_plus1); end
        jump_to(5'd13);
      end else begin
        tick();
      end
    end
    tests++; if (if_pc !== 5'd13) begin fails++; $display("FAIL jal_pc got %0d exp 13", if_pc); end
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL jal_valid got %b exp 1", if_valid); end
    tests++; if (if_instr !== rom[13]) begin fails++; $display("FAIL jal_instr got %h exp %h", if_instr, rom[13]); end
  endtask

  // redir without fire is ignored; 31 wraps to 0.
  task automatic test_redir_wrap();
    jump_to(5'd8);
    tests++; if (if_pc !== 5'd8) begin fails++; $display("FAIL to8_pc got %0d exp 8", if_pc); end
    if_ready = 1'b0; redir = 1'b1; redir_pc = 5'd20;
    tick();
    tests++; if (if_pc !== 5'd8) begin fails++; $display("FAIL noredir_pc got %0d exp 8", if_pc); end
    if_ready = 1'b1; redir = 1'b0; redir_pc = '0;
    tick();
    tests++; if (if_pc !== 5'd9) begin fails++; $display("FAIL after_stall_pc got %0d exp 9", if_pc); end
    jump_to(5'd31);
    tests++; if (if_pc !== 5'd31) begin fails++; $display("FAIL to31_pc got %0d exp 31", if_pc); end
    tests++; if (if_pc_plus1 !== 5'd0) begin fails++; $display("FAIL wrap_plus1 got %0d exp 0", if_pc_plus1); end
    tick();
    tests++; if (if_pc !== 5'd0) begin fails++; $display("FAIL wrap_pc got %0d exp 0", if_pc); end
    tests++; if (if_instr !== 32'h00432020) begin fails++; $display("FAIL wrap_instr got %h exp 00432020", if_instr); end
  endtask

  task automatic test_halt();
    jump_to(5'd5);
    tests++; if (if_pc !== 5'd5) begin fails++; $display("FAIL to5_pc got %0d exp 5", if_pc); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_halted got %b exp 1", halted); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL halt_valid got %b exp 0", if_valid); end
      tests++; if (if_pc !== 5'd6) begin fails++; $display("FAIL halt_pc got %0d exp 6", if_pc); end
      tests++; if (irom_a !== 5'd6) begin fails++; $display("FAIL halt_irom_a got %0d exp 6", irom_a); end
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL resume_valid got %b exp 1", if_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL resume_halted got %b exp 0", halted); end
    tests++; if (if_pc !== 5'd6) begin fails++; $display("FAIL resume_pc got %0d exp 6", if_pc); end
    tests++; if (if_instr !== rom[6]) begin fails++; $display("FAIL resume_instr got %h exp %h", if_instr, rom[6]); end
    // halt_req and resume together in RUN: halt wins, the fire still advances pc.
    halt_req = 1'b1; resume = 1'b1;
    tick();
    halt_req = 1'b0; resume = 1'b0;
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL both_halted got %b exp 1", halted); end
    tests++; if (if_pc !== 5'd7) begin fails++; $display("FAIL both_pc got %0d exp 7", if_pc); end
    resume = 1'b1;
    tick();
    // resume alone in RUN has no effect.
    tick();
    resume = 1'b0;
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL resume_run_halted got %b exp 0", halted); end
    tests++; if (if_pc !== 5'd8) begin fails++; $display("FAIL resume_run_pc got %0d exp 8", if_pc); end
  endtask

  task automatic test_rst_mid();
    jump_to(5'd10);
    tests++; if (if_pc !== 5'd10) begin fails++; $display("FAIL to10_pc got %0d exp 10", if_pc); end
    rst = 1'b1;
    #1;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", if_valid); end
    tests++; if (irom_a !== 5'd0) begin fails++; $display("FAIL midrst_irom_a got %0d exp 0", irom_a); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (if_pc !== 5'd0) begin fails++; $display("FAIL midrst_pc got %0d exp 0", if_pc); end
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL midrst_valid2 got %b exp 1", if_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL midrst_halted got %b exp 0", halted); end
    tests++; if (if_instr !== 32'h00432020) begin fails++; $display("FAIL midrst_instr got %h exp 00432020", if_instr); end
`ifdef IFETCH_PERF_EN
    tests++; if (fetch_cnt !== 32'd0) begin fails++; $display("FAIL fetch_cnt_clr got %0d exp 0", fetch_cnt); end
    tests++; if (redir_cnt !== 32'd0) begin fails++; $display("FAIL redir_cnt_clr got %0d exp 0", redir_cnt); end
    tick();
    jump_to(5'd20);
    tests++; if (fetch_cnt !== 32'd2) begin fails++; $display("FAIL fetch_cnt got %0d exp 2", fetch_cnt); end
    tests++; if (redir_cnt !== 32'd1) begin fails++; $display("FAIL redir_cnt got %0d exp 1", redir_cnt); end
`endif
    // Reset while halted also returns to RUN at RESET_PC.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_rst_halted got %b exp 0", halted); end
    tests++; if (if_pc !== 5'd0) begin fails++; $display("FAIL halt_rst_pc got %0d exp 0", if_pc); end
  endtask

  // ---------------- main ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = {16'hA5C3, 8'h00, 3'b000, 5'(i)};
    rom[0] = 32'h00432020;
    rom[3] = 32'h00831022;
    test_reset();
    test_back_to_back();
    test_redir_wrap();
    test_halt();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
